// File: rtl/xc_aessub_pkg.sv
// Shared constants and helpers for the xcrypto AES SubBytes unit.
// Byte sourcing, step count, lane legality and GF(2^8) S-box maths.
package xc_aessub_pkg;

    // Bit i set: byte i comes from rs2, otherwise from rs1.
    localparam logic [3:0] SRC_RS2 = 4'b1010;
    localparam logic [3:0][4:0] SRC_OFF = {5'd24, 5'd16, 5'd8, 5'd0};

    function automatic logic [7:0] src_byte(
        logic [31:0] rs1,
        logic [31:0] rs2,
        int          i
    );
        logic [31:0] w;
        w = SRC_RS2[i] ? rs2 : rs1;
        return 8'(w >> SRC_OFF[i]);
    endfunction

    function automatic int nstep(int lanes);
        return 4 / lanes;
    endfunction

    function automatic bit lanes_ok(int lanes);
        return (lanes == 1) || (lanes == 2) || (lanes == 4);
    endfunction

    function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse, and maps 0 to 0.
    function automatic logic [7:0] gf_inv(logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15;
        logic [7:0] x30, x60, x120, x240, x252;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    function automatic logic [7:0] rotl(logic [7:0] b, int n);
        logic [15:0] d;
        d = {b, b};
        return d[8-n +: 8];
    endfunction

    function automatic logic [7:0] affine(logic [7:0] b);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3)
                 ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(logic [7:0] b);
        return rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05;
    endfunction

endpackage

// File: rtl/xc_aessub_multi_if.sv
// Request/response bundle between the execute stage and the
// AES SubBytes unit.
interface xc_aessub_multi_if;
    logic        flush;
    logic [31:0] flush_data;
    logic        valid;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        enc;
    logic        rot;
    logic        ready;
    logic [31:0] result;
    logic        busy;

    modport master (
        output flush, flush_data, valid, rs1, rs2, enc, rot,
        input  ready, result, busy
    );

    modport slave (
        input  flush, flush_data, valid, rs1, rs2, enc, rot,
        output ready, result, busy
    );
endinterface

// File: rtl/xc_aessub_sbox.sv
// Single AES forward/inverse S-box built from GF(2^8) inversion.
// One shared inverter serves both directions.
module xc_aessub_sbox
    import xc_aessub_pkg::*;
(
    input  logic [7:0] in,
    input  logic       inv,
    output logic [7:0] out
);
    logic [7:0] t;

    assign t   = gf_inv(inv ? inv_affine(in) : in);
    assign out = inv ? t : affine(t);
endmodule

// File: rtl/xc_aessub_multi.sv
// AES SubBytes/InvSubBytes over LANES S-boxes, 4/LANES cycles per op.
// Earlier steps park their bytes in a buffer; the last step bypasses.
module xc_aessub_multi
    import xc_aessub_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic               clock,
    input  logic               reset,
    xc_aessub_multi_if.slave   bus
);
    localparam int NSTEP = nstep(LANES);
    localparam int LAST  = NSTEP - 1;
    localparam int K     = LAST * LANES;

    if (!lanes_ok(LANES)) begin : g_bad_lanes
        $error("xc_aessub_multi: LANES must be 1, 2 or 4");
    end

    logic [7:0]  src  [4];
    logic [7:0]  sin  [LANES];
    logic [7:0]  sout [LANES];
    logic [7:0]  fin  [4];
    logic [7:0]  res  [4];
    logic [23:0] buffer;
    logic [31:0] buf4;
    logic [1:0]  base;
    logic        wr;
    logic        rdy;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            src[i] = src_byte(bus.rs1, bus.rs2, i);
        end
    end

    // Idle S-boxes see 0x00 so stale operands never toggle them.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [1:0] idx;
        assign idx    = base + 2'(l);
        assign sin[l] = src[idx] & {8{bus.valid}};

        xc_aessub_sbox u_sbox (
            .in  (sin[l]),
            .inv (!bus.enc),
            .out (sout[l])
        );
    end

    for (genvar j = 0; j < 4; j++) begin : g_fin
        if (j < LANES) begin : g_on
            assign fin[j] = sout[j];
        end else begin : g_off
            assign fin[j] = 8'h00;
        end
    end

    if (NSTEP > 1) begin : g_multi
        localparam int SW = $clog2(NSTEP);
        logic [SW-1:0] step;
        logic          last;

        assign last = (step == SW'(LAST));
        assign base = 2'(step * LANES);
        assign wr   = bus.valid && !last && !reset && !bus.flush;
        assign rdy  = bus.valid && last && !reset && !bus.flush;
        assign bus.busy = (step != '0);

        always_ff @(posedge clock) begin
            if (reset || bus.flush) begin
                step <= '0;
            end else if (bus.valid && !last) begin
                step <= step + 1'b1;
            end else begin
                step <= '0;
            end
        end
    end else begin : g_comb
        assign base     = 2'd0;
        assign wr       = 1'b0;
        assign rdy      = bus.valid && !reset && !bus.flush;
        assign bus.busy = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset || bus.flush) begin
            buffer <= bus.flush_data[23:0];
        end else if (wr) begin
            for (int j = 0; j < 3; j++) begin
                for (int l = 0; l < LANES; l++) begin
                    if (int'(base) + l == j) begin
                        buffer[8*j +: 8] <= sout[l];
                    end
                end
            end
        end
    end

    assign buf4 = {8'h00, buffer};

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            res[i] = (i < K) ? buf4[8*i +: 8] : fin[2'(i - K)];
        end
        bus.result = 32'h0;
        if (rdy) begin
            bus.result = bus.rot
                ? {res[2], res[1], res[0], res[3]}
                : {res[3], res[2], res[1], res[0]};
        end
    end

    assign bus.ready = rdy;

endmodule

// File: tb/tb_xc_aessub_multi.sv
// Directed bench for xc_aessub_multi at LANES = 1, 2 and 4.
// Expected words are hand-derived from the AES S-box table.
module tb_xc_aessub_multi;
    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    localparam logic [31:0] A1 = 32'h00530001;
    localparam logic [31:0] A2 = 32'h01000000;
    localparam logic [31:0] B1 = 32'h00ed007c;
    localparam logic [31:0] B2 = 32'h7c006300;
    localparam logic [31:0] C1 = 32'h00ff0010;
    localparam logic [31:0] C2 = 32'h20008000;

    always #5 clock = ~clock;

    xc_aessub_multi_if b1 ();
    xc_aessub_multi_if b2 ();
    xc_aessub_multi_if b4 ();

    xc_aessub_multi #(.LANES(1)) u1 (
        .clock (clock), .reset (reset), .bus (b1)
    );
    xc_aessub_multi #(.LANES(2)) u2 (
        .clock (clock), .reset (reset), .bus (b2)
    );
    xc_aessub_multi #(.LANES(4)) u4 (
        .clock (clock), .reset (reset), .bus (b4)
    );

    // Operands must hold while an instruction is in flight.
    a_hold1: assert property (@(posedge clock) disable iff (reset)
        (b1.busy && b1.valid) |-> ($stable(b1.rs1) && $stable(b1.rs2)
        && $stable(b1.enc) && $stable(b1.rot)));
    a_hold2: assert property (@(posedge clock) disable iff (reset)
        (b2.busy && b2.valid) |-> ($stable(b2.rs1) && $stable(b2.rs2)
        && $stable(b2.enc) && $stable(b2.rot)));

    task automatic check(string tag, logic [31:0] got,
                         logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic set_fd(logic [31:0] d);
        b1.flush_data = d;
        b2.flush_data = d;
        b4.flush_data = d;
    endtask

    task automatic drive(int u, logic v, logic [31:0] a,
                         logic [31:0] b, logic e, logic r,
                         logic f);
        b1.valid = 1'b0; b1.flush = 1'b0;
        b2.valid = 1'b0; b2.flush = 1'b0;
        b4.valid = 1'b0; b4.flush = 1'b0;
        case (u)
            1: begin
                b1.valid = v; b1.rs1 = a; b1.rs2 = b;
                b1.enc = e; b1.rot = r; b1.flush = f;
            end
            2: begin
                b2.valid = v; b2.rs1 = a; b2.rs2 = b;
                b2.enc = e; b2.rot = r; b2.flush = f;
            end
            default: begin
                b4.valid = v; b4.rs1 = a; b4.rs2 = b;
                b4.enc = e; b4.rot = r; b4.flush = f;
            end
        endcase
    endtask

    task automatic init_if();
        b1.rs1 = 0; b1.rs2 = 0; b1.enc = 0; b1.rot = 0;
        b2.rs1 = 0; b2.rs2 = 0; b2.enc = 0; b2.rot = 0;
        b4.rs1 = 0; b4.rs2 = 0; b4.enc = 0; b4.rot = 0;
    endtask

    initial begin
        reset = 1'b1;
        init_if();
        set_fd(32'h0);
        drive(4, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        #1;
        check("rst_ready1", 32'(b1.ready), 32'd0);
        check("rst_result1", b1.result, 32'h0);
        check("rst_busy1", 32'(b1.busy), 32'd0);
        check("rst_ready4", 32'(b4.ready), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("idle_busy2", 32'(b2.busy), 32'd0);
        check("idle_result1", b1.result, 32'h0);
        @(negedge clock);

        // Combinational configuration
        drive(4, 1, A1, A2, 1, 0, 0); #1;
        check("l4_ready", 32'(b4.ready), 32'd1);
        check("l4_fwd", b4.result, 32'h7ced637c);
        @(negedge clock);
        drive(4, 1, A1, A2, 1, 1, 0); #1;
        check("l4_rot", b4.result, 32'hed637c7c);
        @(negedge clock);
        drive(4, 1, B1, B2, 0, 0, 0); #1;
        check("l4_inv", b4.result, 32'h01530001);
        @(negedge clock);
        drive(4, 1, C1, C2, 1, 0, 0); #1;
        check("l4_fwd2", b4.result, 32'hb716cdca);
        @(negedge clock);
        drive(4, 1, C1, C2, 1, 0, 1); #1;
        check("l4_flush_rdy", 32'(b4.ready), 32'd0);
        check("l4_flush_res", b4.result, 32'h0);
        @(negedge clock);
        drive(4, 0, C1, C2, 1, 0, 0); #1;
        check("l4_idle_res", b4.result, 32'h0);
        @(negedge clock);

        // One lane, two instructions back to back
        for (int c = 1; c <= 4; c++) begin
            drive(1, 1, A1, A2, 1, 0, 0); #1;
            check("l1_ready", 32'(b1.ready), 32'(c == 4));
            check("l1_busy", 32'(b1.busy), 32'(c > 1));
            check("l1_res", b1.result,
                  (c == 4) ? 32'h7ced637c : 32'h0);
            @(negedge clock);
        end
        for (int c = 1; c <= 4; c++) begin
            drive(1, 1, C1, C2, 1, 0, 0); #1;
            check("l1b_ready", 32'(b1.ready), 32'(c == 4));
            if (c == 4) check("l1b_res", b1.result, 32'hb716cdca);
            @(negedge clock);
        end

        // Two lanes: abort then re-issue
        drive(2, 0, 0, 0, 0, 0, 0); #1;
        @(negedge clock);
        drive(2, 1, A1, A2, 1, 1, 0); #1;
        check("l2_ab_rdy0", 32'(b2.ready), 32'd0);
        check("l2_ab_busy0", 32'(b2.busy), 32'd0);
        @(negedge clock);
        drive(2, 0, 0, 0, 0, 0, 0); #1;
        check("l2_ab_busy1", 32'(b2.busy), 32'd1);
        check("l2_ab_rdy1", 32'(b2.ready), 32'd0);
        check("l2_ab_res", b2.result, 32'h0);
        @(negedge clock);
        drive(2, 0, 0, 0, 0, 0, 0); #1;
        check("l2_ab_busy2", 32'(b2.busy), 32'd0);
        @(negedge clock);
        for (int c = 1; c <= 2; c++) begin
            drive(2, 1, A1, A2, 1, 1, 0); #1;
            check("l2_ready", 32'(b2.ready), 32'(c == 2));
            if (c == 2) check("l2_rot", b2.result, 32'hed637c7c);
            @(negedge clock);
        end
        for (int c = 1; c <= 2; c++) begin
            drive(2, 1, B1, B2, 0, 0, 0); #1;
            check("l2i_ready", 32'(b2.ready), 32'(c == 2));
            if (c == 2) check("l2_inv", b2.result, 32'h01530001);
            @(negedge clock);
        end

        // One lane: flush at step 2
        set_fd(32'haabbccdd);
        for (int c = 1; c <= 3; c++) begin
            drive(1, 1, A1, A2, 1, 0, c == 3); #1;
            check("fl_ready", 32'(b1.ready), 32'd0);
            @(negedge clock);
        end
        drive(1, 0, 0, 0, 0, 0, 0); #1;
        check("fl_busy", 32'(b1.busy), 32'd0);
        check("fl_res", b1.result, 32'h0);
        @(negedge clock);
        for (int c = 1; c <= 4; c++) begin
            drive(1, 1, C1, C2, 1, 1, 0); #1;
            check("fl_nx_rdy", 32'(b1.ready), 32'(c == 4));
            if (c == 4) check("fl_nx_res", b1.result, 32'h16cdcab7);
            @(negedge clock);
        end

        // Reset in the middle of an instruction
        for (int c = 1; c <= 2; c++) begin
            drive(1, 1, A1, A2, 1, 0, 0);
            @(negedge clock);
        end
        reset = 1'b1;
        drive(1, 1, A1, A2, 1, 0, 0); #1;
        check("mr_ready", 32'(b1.ready), 32'd0);
        check("mr_res", b1.result, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        drive(1, 0, A1, A2, 1, 0, 0); #1;
        check("mr_busy", 32'(b1.busy), 32'd0);
        @(negedge clock);
        for (int c = 0; c < 3; c++) begin
            drive(1, 0, A1, A2, 1, 0, 0); #1;
            check("idle_r1", b1.result, 32'h0);
            check("idle_r2", b2.result, 32'h0);
            check("idle_r4", b4.result, 32'h0);
            @(negedge clock);
        end
        for (int c = 1; c <= 4; c++) begin
            drive(1, 1, A1, A2, 1, 0, 0); #1;
            check("mr_nx_rdy", 32'(b1.ready), 32'(c == 4));
            if (c == 4) check("mr_nx_res", b1.result, 32'h7ced637c);
            @(negedge clock);
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
